// File: rtl/painel_entrada.sv
// Input front end: synchronises and debounces note buttons and navigation keys, encodes the
// active note with a small FSM and emits active-low navigation strobes with arrow auto-repeat.
module painel_entrada #(
    parameter int unsigned CLOCK_FREQ      = 50000000,
    parameter int unsigned N_BOTOES        = 12,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 150
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                right_arrow,
    input  logic                left_arrow,
    input  logic                enter,
    output logic [3:0]          botoes_encoded,
    output logic                nota_pulso,
    output logic                right_arrow_pressed,
    output logic                left_arrow_pressed,
    output logic                enter_pressed,
    output logic [1:0]          db_estado
);

    localparam int unsigned TickDiv = CLOCK_FREQ / 1000;
    localparam int unsigned NIn     = N_BOTOES + 3;
    localparam int unsigned TickW   = $clog2(TickDiv + 1);
    localparam int unsigned DbW     = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned RepMax  = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                         : REPEAT_RATE_MS;
    localparam int unsigned RepW    = $clog2(RepMax + 1);

    typedef enum logic [1:0] {
        StOcioso      = 2'd0,
        StPressionado = 2'd1,
        StSoltando    = 2'd2
    } estado_t;

    // Navigation bits sit above the notes: [N]=right, [N+1]=left, [N+2]=enter.
    logic [NIn-1:0]           raw;
    logic [NIn-1:0]           sync1_q, sync2_q;
    logic [NIn-1:0]           db_q;
    logic [NIn-1:0][DbW-1:0]  db_cnt_q;
    logic [TickW-1:0]         tick_cnt_q;
    logic                     tick;

    assign raw  = {enter, left_arrow, right_arrow, botoes};
    assign tick = (tick_cnt_q == TickW'(TickDiv - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
            db_q       <= '0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
            if (tick) begin
                for (int i = 0; i < NIn; i++) begin
                    if (sync2_q[i] != db_q[i]) begin
                        if (db_cnt_q[i] == DbW'(DEBOUNCE_MS - 1)) begin
                            db_q[i]     <= sync2_q[i];
                            db_cnt_q[i] <= '0;
                        end else begin
                            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                        end
                    end else begin
                        db_cnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    // Note FSM
    logic [N_BOTOES-1:0] notas;
    logic [3:0]          low_code;
    logic                held;
    estado_t             state_q, state_d;
    logic [3:0]          code_q, code_d;
    logic                pulse_q, pulse_d;

    assign notas = db_q[N_BOTOES-1:0];

    always_comb begin
        low_code = '0;
        held     = 1'b0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (notas[i]) low_code = 4'(i + 1);
        end
        for (int i = 0; i < N_BOTOES; i++) begin
            if (code_q == 4'(i + 1)) held = notas[i];
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pulse_d = 1'b0;
        unique case (state_q)
            StOcioso: begin
                if (|notas) begin
                    code_d  = low_code;
                    pulse_d = 1'b1;
                    state_d = StPressionado;
                end
            end
            StPressionado: begin
                if (!held) begin
                    code_d  = '0;
                    state_d = StSoltando;
                end
            end
            StSoltando: state_d = StOcioso;
            default: begin
                code_d  = '0;
                state_d = StOcioso;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StOcioso;
            code_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
        end
    end

    assign botoes_encoded = code_q;
    assign nota_pulso     = pulse_q;
    assign db_estado      = state_q;

    // Navigation
    logic [2:0]            nav, nav_prev_q, rise, strobe_q;
    logic [1:0][RepW-1:0]  rep_cnt_q, rep_cnt_d;
    logic [1:0]            armed_q, armed_d, fire, fire_q;
    logic                  both;

    assign nav  = db_q[NIn-1:N_BOTOES];
    assign rise = nav & ~nav_prev_q;
    assign both = nav[0] & nav[1];

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        armed_d   = armed_q;
        fire      = '0;
        for (int j = 0; j < 2; j++) begin
            if (!nav[j] || both) begin
                rep_cnt_d[j] = '0;
                armed_d[j]   = 1'b0;
            end else if (tick) begin
                if ((!armed_q[j] && rep_cnt_q[j] == RepW'(REPEAT_DELAY_MS - 1)) ||
                    (armed_q[j] && rep_cnt_q[j] == RepW'(REPEAT_RATE_MS - 1))) begin
                    fire[j]      = 1'b1;
                    rep_cnt_d[j] = '0;
                    armed_d[j]   = 1'b1;
                end else begin
                    rep_cnt_d[j] = rep_cnt_q[j] + RepW'(1);
                end
            end
        end
    end

    // fire is delayed one cycle so repeat spacing matches the edge-detect latency of the press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nav_prev_q <= '0;
            rep_cnt_q  <= '0;
            armed_q    <= '0;
            fire_q     <= '0;
            strobe_q   <= '0;
        end else begin
            nav_prev_q <= nav;
            rep_cnt_q  <= rep_cnt_d;
            armed_q    <= armed_d;
            fire_q     <= fire;
            strobe_q   <= {rise[2], rise[1] | fire_q[1], rise[0] | fire_q[0]};
        end
    end

    assign right_arrow_pressed = ~strobe_q[0];
    assign left_arrow_pressed  = ~strobe_q[1];
    assign enter_pressed       = ~strobe_q[2];

endmodule

// File: tb/tb_painel_entrada.sv
// Directed self-checking bench for painel_entrada with a 4-cycle ms tick.
module tb_painel_entrada;

    logic        clock;
    logic        reset;
    logic [11:0] botoes;
    logic        right_arrow, left_arrow, enter;
    logic [3:0]  botoes_encoded;
    logic        nota_pulso;
    logic        right_arrow_pressed, left_arrow_pressed, enter_pressed;
    logic [1:0]  db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    painel_entrada #(
        .CLOCK_FREQ      (4000),
        .N_BOTOES        (12),
        .DEBOUNCE_MS     (3),
        .REPEAT_DELAY_MS (10),
        .REPEAT_RATE_MS  (4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .botoes              (botoes),
        .right_arrow         (right_arrow),
        .left_arrow          (left_arrow),
        .enter               (enter),
        .botoes_encoded      (botoes_encoded),
        .nota_pulso          (nota_pulso),
        .right_arrow_pressed (right_arrow_pressed),
        .left_arrow_pressed  (left_arrow_pressed),
        .enter_pressed       (enter_pressed),
        .db_estado           (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0; botoes = '0; right_arrow = 0; left_arrow = 0; enter = 0;
        settle(3);
        n_tests++;
        if (botoes_encoded !== 4'd0) begin
            n_fail++; $display("FAIL reset_encoded got %0d want 0", botoes_encoded);
        end
        n_tests++;
        if (nota_pulso !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulso got %0b want 0", nota_pulso);
        end
        n_tests++;
        if ({right_arrow_pressed, left_arrow_pressed, enter_pressed} !== 3'b111) begin
            n_fail++; $display("FAIL reset_strobes got %b want 111",
                               {right_arrow_pressed, left_arrow_pressed, enter_pressed});
        end
        n_tests++;
        if (db_estado !== 2'd0) begin
            n_fail++; $display("FAIL reset_estado got %0d want 0", db_estado);
        end
        reset = 1'b1;
        settle(20);
        n_tests++;
        if (botoes_encoded !== 4'd0 || db_estado !== 2'd0) begin
            n_fail++; $display("FAIL idle_after_reset got enc=%0d st=%0d want 0/0",
                               botoes_encoded, db_estado);
        end
    endtask

    task automatic test_bounce();
        int changed = 0;
        int pulses  = 0;
        int lat     = -1;
        for (int c = 0; c < 20; c++) begin
            if (c % 3 == 0) botoes[5] = ~botoes[5];
            @(negedge clock);
            if (botoes_encoded !== 4'd0 || nota_pulso !== 1'b0) changed++;
        end
        // botoes[5] was last driven high at c=18, two edges ago
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (nota_pulso === 1'b1) pulses++;
            if (botoes_encoded === 4'd6 && lat < 0) lat = c + 3;
        end
        n_tests++;
        if (changed != 0) begin
            n_fail++; $display("FAIL bounce_quiet got %0d changes want 0", changed);
        end
        n_tests++;
        if (lat < 0 || lat > 15) begin
            n_fail++; $display("FAIL bounce_latency got %0d want 1..15", lat);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL bounce_pulses got %0d want 1", pulses);
        end
        botoes = '0;
        settle(30);
    endtask

    task automatic test_multi_press();
        int pulses = 0;
        int first  = -1;
        int sol    = 0;
        int bad    = 0;
        botoes = 12'h024;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (nota_pulso === 1'b1) pulses++;
            if (botoes_encoded !== 4'd0 && first < 0) first = int'(botoes_encoded);
        end
        n_tests++;
        if (first != 3) begin
            n_fail++; $display("FAIL multi_first_code got %0d want 3", first);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL multi_first_pulses got %0d want 1", pulses);
        end
        pulses = 0;
        botoes = 12'h020;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (nota_pulso === 1'b1) pulses++;
            if (db_estado === 2'd2) begin
                sol++;
                if (botoes_encoded !== 4'd0) bad++;
            end
        end
        n_tests++;
        if (sol != 1 || bad != 0) begin
            n_fail++; $display("FAIL multi_soltando got %0d cycles (%0d nonzero) want 1 (0)",
                               sol, bad);
        end
        n_tests++;
        if (botoes_encoded !== 4'd6) begin
            n_fail++; $display("FAIL multi_relatch got %0d want 6", botoes_encoded);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL multi_second_pulse got %0d want 1", pulses);
        end
        botoes = '0;
        settle(30);
    endtask

    task automatic test_ignore_held();
        int wrong  = 0;
        int pulses = 0;
        botoes[0] = 1'b1;
        settle(30);
        n_tests++;
        if (botoes_encoded !== 4'd1) begin
            n_fail++; $display("FAIL ignore_first got %0d want 1", botoes_encoded);
        end
        botoes[7] = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (c == 40) botoes[7] = 1'b0;
            @(negedge clock);
            if (botoes_encoded !== 4'd1) wrong++;
            if (nota_pulso === 1'b1) pulses++;
        end
        n_tests++;
        if (wrong != 0) begin
            n_fail++; $display("FAIL ignore_hold got %0d wrong cycles want 0", wrong);
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL ignore_pulses got %0d want 0", pulses);
        end
        botoes = '0;
        settle(30);
    endtask

    task automatic test_arrow_repeat();
        int idx[$];
        int others = 0;
        int exp_gap[4];
        exp_gap = '{40, 16, 16, 16};
        right_arrow = 1'b1;
        // 24 ms hold: press, +10 ms, then three repeats 4 ms apart
        for (int c = 0; c < 136; c++) begin
            if (c == 96) right_arrow = 1'b0;
            @(negedge clock);
            if (right_arrow_pressed === 1'b0) idx.push_back(c);
            if (left_arrow_pressed !== 1'b1 || enter_pressed !== 1'b1) others++;
        end
        n_tests++;
        if (idx.size() != 5) begin
            n_fail++; $display("FAIL arrow_count got %0d want 5", idx.size());
        end
        if (idx.size() == 5) begin
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (idx[k+1] - idx[k] != exp_gap[k]) begin
                    n_fail++; $display("FAIL arrow_gap%0d got %0d want %0d",
                                       k, idx[k+1] - idx[k], exp_gap[k]);
                end
            end
        end
        n_tests++;
        if (others != 0) begin
            n_fail++; $display("FAIL arrow_others got %0d low cycles want 0", others);
        end
        settle(20);
    endtask

    task automatic test_enter_both();
        int en = 0, rl = 0, ll = 0, other = 0;
        int r_at = -1, l_at = -2;
        enter = 1'b1;
        for (int c = 0; c < 160; c++) begin
            if (c == 120) enter = 1'b0;
            @(negedge clock);
            if (enter_pressed === 1'b0) en++;
            if (right_arrow_pressed !== 1'b1 || left_arrow_pressed !== 1'b1) other++;
        end
        n_tests++;
        if (en != 1 || other != 0) begin
            n_fail++; $display("FAIL enter_once got %0d lows (%0d arrow) want 1 (0)", en, other);
        end
        right_arrow = 1'b1; left_arrow = 1'b1;
        for (int c = 0; c < 160; c++) begin
            if (c == 120) begin right_arrow = 1'b0; left_arrow = 1'b0; end
            @(negedge clock);
            if (right_arrow_pressed === 1'b0) begin rl++; r_at = c; end
            if (left_arrow_pressed === 1'b0) begin ll++; l_at = c; end
        end
        n_tests++;
        if (rl != 1 || ll != 1) begin
            n_fail++; $display("FAIL both_no_repeat got right=%0d left=%0d want 1/1", rl, ll);
        end
        n_tests++;
        if (r_at != l_at) begin
            n_fail++; $display("FAIL both_same_cycle got right@%0d left@%0d want equal",
                               r_at, l_at);
        end
        settle(20);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int lat    = -1;
        botoes[3] = 1'b1;
        settle(30);
        n_tests++;
        if (botoes_encoded !== 4'd4) begin
            n_fail++; $display("FAIL mid_pre got %0d want 4", botoes_encoded);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (botoes_encoded !== 4'd0 || db_estado !== 2'd0 || nota_pulso !== 1'b0) begin
            n_fail++; $display("FAIL mid_async got enc=%0d st=%0d p=%0b want 0/0/0",
                               botoes_encoded, db_estado, nota_pulso);
        end
        settle(3);
        n_tests++;
        if ({right_arrow_pressed, left_arrow_pressed, enter_pressed} !== 3'b111) begin
            n_fail++; $display("FAIL mid_strobes got %b want 111",
                               {right_arrow_pressed, left_arrow_pressed, enter_pressed});
        end
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (nota_pulso === 1'b1) pulses++;
            if (botoes_encoded === 4'd4 && lat < 0) lat = c + 1;
        end
        n_tests++;
        if (lat < 2 || lat > 16) begin
            n_fail++; $display("FAIL mid_relatch_latency got %0d want 2..16", lat);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL mid_pulse got %0d want 1", pulses);
        end
        botoes = '0;
        settle(30);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_multi_press();
        test_ignore_held();
        test_arrow_repeat();
        test_enter_both();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
